// File: rtl/hpu_reset_seq.sv
// hpu_reset_seq: reset sequencer feeding the per-part reset distribution.
// Combines the board reset, PLL/MMCM lock and a software request into one
// reset per part. All parts are held for HOLD_CYCLES after lock is seen, then
// released in part order, STAGGER_CYCLES apart.
//
//   state | meaning
//   ------+--------------------------------------------------------------
//   WAIT  | all parts asserted, waiting for synchronized lock
//   HOLD  | all parts asserted, counting the minimum hold time
//   REL   | staggered release in progress, one part per stagger period
//   RUN   | all parts released, rst_done=1
(* keep_hierarchy = "yes" *)
module hpu_reset_seq #(
  parameter logic RST_POL        = 1'b0,
  parameter int   PART_NB        = 3,
  parameter int   HOLD_CYCLES    = 16,
  parameter int   STAGGER_CYCLES = 4,
  parameter int   SYNC_STAGES    = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clk_locked,
  input  logic               sw_rst_req,
  output logic [PART_NB-1:0] rst_part,
  output logic               rst_done,
  output logic               seq_busy
);

  localparam int MAX_C = (HOLD_CYCLES > STAGGER_CYCLES) ? HOLD_CYCLES : STAGGER_CYCLES;
  localparam int CNT_W = $clog2(MAX_C + 1);
  // idx may step one past the last part when STAGGER_CYCLES==1
  localparam int IDX_W = $clog2(PART_NB + 1);

  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] STAG_LAST = CNT_W'(STAGGER_CYCLES - 1);

  typedef enum logic [1:0] {
    S_WAIT = 2'd0,
    S_HOLD = 2'd1,
    S_REL  = 2'd2,
    S_RUN  = 2'd3
  } state_t;

  (* ASYNC_REG = "TRUE" *) logic [SYNC_STAGES-1:0] rst_sync_q;
  (* ASYNC_REG = "TRUE" *) logic [SYNC_STAGES-1:0] lock_sync_q;

  logic rst_int;
  logic lock_s;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [PART_NB-1:0] rel_q, rel_d;
  logic [PART_NB-1:0] rst_part_q, rst_part_d;
  logic               rst_done_q, rst_done_d;
  logic               seq_busy_q, seq_busy_d;

  // Reset synchronizer: asserts with rst, releases after SYNC_STAGES edges.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) rst_sync_q <= '1;
    else     rst_sync_q <= {rst_sync_q[SYNC_STAGES-2:0], 1'b0};
  end

  // Lock synchronizer: clk_locked is asynchronous to clk.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) lock_sync_q <= '0;
    else     lock_sync_q <= {lock_sync_q[SYNC_STAGES-2:0], clk_locked};
  end

  assign rst_int = rst_sync_q[SYNC_STAGES-1];
  assign lock_s  = lock_sync_q[SYNC_STAGES-1];

  // Next-state logic; lock loss outranks a software request.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    rel_d   = rel_q;

    if (rst_int) begin
      state_d = S_WAIT;
      cnt_d   = '0;
      idx_d   = '0;
      rel_d   = '0;
    end else if (state_q != S_WAIT && !lock_s) begin
      state_d = S_WAIT;
      cnt_d   = '0;
      idx_d   = '0;
      rel_d   = '0;
    end else if (state_q != S_WAIT && sw_rst_req) begin
      state_d = S_HOLD;
      cnt_d   = '0;
      idx_d   = '0;
      rel_d   = '0;
    end else begin
      case (state_q)
        S_WAIT: begin
          if (lock_s) begin
            state_d = S_HOLD;
            cnt_d   = '0;
          end
        end
        S_HOLD: begin
          if (cnt_q == HOLD_LAST) begin
            state_d = S_REL;
            cnt_d   = '0;
            idx_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        S_REL: begin
          // Leave one cycle after the last part was released
          if (&rel_q) begin
            state_d = S_RUN;
            cnt_d   = '0;
          end else begin
            if (cnt_q == '0) begin
              for (int k = 0; k < PART_NB; k++) begin
                if (idx_q == IDX_W'(k)) rel_d[k] = 1'b1;
              end
            end
            if (cnt_q == STAG_LAST) begin
              cnt_d = '0;
              idx_d = idx_q + IDX_W'(1);
            end else begin
              cnt_d = cnt_q + CNT_W'(1);
            end
          end
        end
        S_RUN: begin
          state_d = S_RUN;
        end
        default: begin
          state_d = S_WAIT;
          cnt_d   = '0;
          idx_d   = '0;
          rel_d   = '0;
        end
      endcase
    end

    rst_part_d = rel_d ^ {PART_NB{RST_POL}};
    rst_done_d = (state_d == S_RUN);
    seq_busy_d = (state_d == S_HOLD) || (state_d == S_REL);
  end

  // State and registered outputs; rst forces the safe values immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_WAIT;
      cnt_q      <= '0;
      idx_q      <= '0;
      rel_q      <= '0;
      rst_part_q <= {PART_NB{RST_POL}};
      rst_done_q <= 1'b0;
      seq_busy_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      rel_q      <= rel_d;
      rst_part_q <= rst_part_d;
      rst_done_q <= rst_done_d;
      seq_busy_q <= seq_busy_d;
    end
  end

  assign rst_part = rst_part_q;
  assign rst_done = rst_done_q;
  assign seq_busy = seq_busy_q;

endmodule

// File: tb/tb_hpu_reset_seq.sv
// Directed bench for hpu_reset_seq: a default 3-part instance driven by a
// per-step vector table, plus a single-part active-high instance.
module tb_hpu_reset_seq;

  logic       clk;
  logic       rst;
  logic       clk_locked;
  logic       sw_rst_req;
  logic [2:0] rst_part;
  logic       rst_done;
  logic       seq_busy;
  logic [0:0] rst_part1;
  logic       rst_done1;
  logic       seq_busy1;

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    int         ncyc;
    logic       lock;
    logic       sw;
    logic [2:0] part;
    logic       done;
    logic       busy;
  } vec_t;

  vec_t vt[$];

  hpu_reset_seq dut (
    .clk        (clk),
    .rst        (rst),
    .clk_locked (clk_locked),
    .sw_rst_req (sw_rst_req),
    .rst_part   (rst_part),
    .rst_done   (rst_done),
    .seq_busy   (seq_busy)
  );

  hpu_reset_seq #(
    .RST_POL        (1'b1),
    .PART_NB        (1),
    .HOLD_CYCLES    (16),
    .STAGGER_CYCLES (1),
    .SYNC_STAGES    (2)
  ) dut1 (
    .clk        (clk),
    .rst        (rst),
    .clk_locked (clk_locked),
    .sw_rst_req (sw_rst_req),
    .rst_part   (rst_part1),
    .rst_done   (rst_done1),
    .seq_busy   (seq_busy1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic chk0(input string name, input logic [2:0] p, input logic d, input logic b);
    chk({name, " part"}, 32'(rst_part), 32'(p));
    chk({name, " done"}, 32'(rst_done), 32'(d));
    chk({name, " busy"}, 32'(seq_busy), 32'(b));
  endtask

  task automatic chk1(input string name, input logic p, input logic d, input logic b);
    chk({name, " p1 part"}, 32'(rst_part1), 32'(p));
    chk({name, " p1 done"}, 32'(rst_done1), 32'(d));
    chk({name, " p1 busy"}, 32'(seq_busy1), 32'(b));
  endtask

  initial begin
    // Steps counted in edges after rst release (E0); T0 = E3 with lock high.
    vt.push_back('{2,  1'b1, 1'b0, 3'b000, 1'b0, 1'b0}); // E2 still WAIT
    vt.push_back('{1,  1'b1, 1'b0, 3'b000, 1'b0, 1'b1}); // E3 HOLD
    vt.push_back('{16, 1'b1, 1'b0, 3'b000, 1'b0, 1'b1}); // E19 last held cycle
    vt.push_back('{1,  1'b1, 1'b0, 3'b001, 1'b0, 1'b1}); // E20 part0
    vt.push_back('{3,  1'b1, 1'b0, 3'b001, 1'b0, 1'b1}); // E23
    vt.push_back('{1,  1'b1, 1'b0, 3'b011, 1'b0, 1'b1}); // E24 part1
    vt.push_back('{3,  1'b1, 1'b0, 3'b011, 1'b0, 1'b1}); // E27
    vt.push_back('{1,  1'b1, 1'b0, 3'b111, 1'b0, 1'b1}); // E28 part2
    vt.push_back('{1,  1'b1, 1'b0, 3'b111, 1'b1, 1'b0}); // E29 RUN
    vt.push_back('{6,  1'b1, 1'b0, 3'b111, 1'b1, 1'b0}); // E35
    vt.push_back('{2,  1'b0, 1'b0, 3'b111, 1'b1, 1'b0}); // E37 loss in sync
    vt.push_back('{1,  1'b0, 1'b0, 3'b000, 1'b0, 1'b0}); // E38 WAIT
    vt.push_back('{3,  1'b0, 1'b0, 3'b000, 1'b0, 1'b0}); // E41
    vt.push_back('{2,  1'b1, 1'b0, 3'b000, 1'b0, 1'b0}); // E43 relock in sync
    vt.push_back('{1,  1'b1, 1'b0, 3'b000, 1'b0, 1'b1}); // E44 HOLD
    vt.push_back('{16, 1'b1, 1'b0, 3'b000, 1'b0, 1'b1}); // E60 full hold
    vt.push_back('{1,  1'b1, 1'b0, 3'b001, 1'b0, 1'b1}); // E61 part0
    vt.push_back('{12, 1'b1, 1'b0, 3'b111, 1'b1, 1'b0}); // E73 RUN
    vt.push_back('{1,  1'b1, 1'b1, 3'b000, 1'b0, 1'b1}); // E74 sw in RUN
    vt.push_back('{10, 1'b1, 1'b0, 3'b000, 1'b0, 1'b1}); // E84 cnt=10
    vt.push_back('{1,  1'b1, 1'b1, 3'b000, 1'b0, 1'b1}); // E85 restart
    vt.push_back('{16, 1'b1, 1'b0, 3'b000, 1'b0, 1'b1}); // E101 still held
    vt.push_back('{1,  1'b1, 1'b0, 3'b001, 1'b0, 1'b1}); // E102 part0
    vt.push_back('{9,  1'b1, 1'b0, 3'b111, 1'b1, 1'b0}); // E111 RUN
    vt.push_back('{2,  1'b0, 1'b0, 3'b111, 1'b1, 1'b0}); // E113
    vt.push_back('{1,  1'b0, 1'b1, 3'b000, 1'b0, 1'b0}); // E114 loss+sw -> WAIT
    vt.push_back('{1,  1'b0, 1'b0, 3'b000, 1'b0, 1'b0}); // E115

    rst        = 1'b1;
    clk_locked = 1'b1;
    sw_rst_req = 1'b0;
    repeat (3) tick();
    chk0("in reset", 3'b000, 1'b0, 1'b0);
    chk1("in reset", 1'b1, 1'b0, 1'b0);

    rst = 1'b0;
    for (int i = 0; i < vt.size(); i++) begin
      clk_locked = vt[i].lock;
      sw_rst_req = vt[i].sw;
      repeat (vt[i].ncyc) tick();
      sw_rst_req = 1'b0;
      chk0($sformatf("vec%0d", i), vt[i].part, vt[i].done, vt[i].busy);
    end

    // Async reset in the middle of the release phase
    rst        = 1'b1;
    clk_locked = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    repeat (21) tick();
    chk0("midrel before rst", 3'b001, 1'b0, 1'b1);
    #3 rst = 1'b1;
    #1;
    chk0("midrel async", 3'b000, 1'b0, 1'b0);
    chk1("midrel async", 1'b1, 1'b0, 1'b0);
    repeat (3) tick();
    rst = 1'b0;
    repeat (19) tick();
    chk0("rerun E19", 3'b000, 1'b0, 1'b1);
    chk1("rerun E19", 1'b1, 1'b0, 1'b1);
    tick();
    chk0("rerun E20", 3'b001, 1'b0, 1'b1);
    chk1("rerun E20", 1'b0, 1'b0, 1'b1);
    tick();
    chk0("rerun E21", 3'b001, 1'b0, 1'b1);
    chk1("rerun E21", 1'b0, 1'b1, 1'b0);
    repeat (8) tick();
    chk0("rerun E29", 3'b111, 1'b1, 1'b0);
    chk1("rerun E29", 1'b0, 1'b1, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
